// File: rtl/pwm_pkg.sv
// pwm_pkg: constants and types shared by the PWM generator and the
// PWM duty decoder.
//   DUTY_MAX    : full-scale duty value in tenths (10 = 100 %)
//   DUTY_W      : width of a duty value
//   DUTY_MAX_V  : DUTY_MAX already sized to DUTY_W
//   dec_state_t : decoder divider FSM states
//   clamp_duty  : limits a quotient to DUTY_MAX
package pwm_pkg;

    localparam int unsigned DUTY_MAX = 10;
    localparam int unsigned DUTY_W   = 4;

    localparam logic [DUTY_W-1:0] DUTY_MAX_V = DUTY_W'(DUTY_MAX);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } dec_state_t;

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] q);
        return (q > DUTY_MAX_V) ? DUTY_MAX_V : q;
    endfunction

endpackage

// File: rtl/pwm_duty_div.sv
// pwm_duty_div: repeated-subtraction divider that turns a captured
// (period, high) pair into a rounded duty value in tenths.
//   clk, rst : clock, synchronous active-high reset
//   start_i  : capture request; accepted only in IDLE, ignored otherwise
//   per_i    : captured period in clk cycles (never 0 when start_i is high)
//   hi_i     : captured high time in clk cycles
//   done_o   : high for the single DONE cycle; per_o/hi_o/duty_o valid then
//   per_o    : period held for the current/last division
//   hi_o     : high time held for the current/last division
//   duty_o   : round(hi*10/per), clamped to DUTY_MAX
module pwm_duty_div
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  per_i,
    input  logic [CNT_W-1:0]  hi_i,
    output logic              done_o,
    output logic [CNT_W-1:0]  per_o,
    output logic [CNT_W-1:0]  hi_o,
    output logic [DUTY_W-1:0] duty_o
);

    // hi*10 + per/2 fits in CNT_W+4 bits for any hi, per < 2^CNT_W.
    localparam int unsigned REM_W = CNT_W + 4;

    dec_state_t         state_q;
    logic [REM_W-1:0]   rem_q;
    logic [DUTY_W-1:0]  q_q;
    logic [CNT_W-1:0]   per_q;
    logic [CNT_W-1:0]   hi_q;
    logic [REM_W-1:0]   per_ext;

    assign per_ext = REM_W'(per_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            q_q     <= '0;
            per_q   <= '0;
            hi_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        per_q   <= per_i;
                        hi_q    <= hi_i;
                        // Adding per/2 before dividing rounds to nearest.
                        rem_q   <= REM_W'(hi_i) * REM_W'(10) + REM_W'(per_i >> 1);
                        q_q     <= '0;
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    // The all-ones stop keeps q from wrapping should a
                    // malformed pair ever arrive; real inputs end at q <= 10.
                    if ((rem_q >= per_ext) && (q_q != '1)) begin
                        rem_q <= rem_q - per_ext;
                        q_q   <= q_q + DUTY_W'(1);
                    end else begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign done_o = (state_q == DONE);
    assign per_o  = per_q;
    assign hi_o   = hi_q;
    assign duty_o = clamp_duty(q_q);

endmodule

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures period and high time of an incoming PWM
// waveform in clk cycles and reports the duty cycle in tenths.
//   clk        : single clock
//   rst        : synchronous active-high reset
//   pwm_in     : asynchronous PWM input
//   period_out : cycles between the last two rising edges (0 when stuck)
//   high_out   : high cycles within that period (0 when stuck)
//   duty_out   : duty in tenths 0..10 (10/0 for a line stuck high/low)
//   valid      : one-cycle pulse when the three outputs update
//   stuck      : no rising edge for 2^CNT_W-1 cycles; cleared by next rise
module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  period_out,
    output logic [CNT_W-1:0]  high_out,
    output logic [DUTY_W-1:0] duty_out,
    output logic              valid,
    output logic              stuck
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Input conditioning
    logic sync1_q;
    logic sync2_q;
    logic dly_q;
    logic rise;

    // Measurement state
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q,  hi_cnt_d;
    logic             armed_q,   armed_d;
    logic             stuck_q,   stuck_d;
    logic             capture;
    logic             stuck_fire;

    // Registered outputs
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_q,   high_d;
    logic [DUTY_W-1:0] duty_q,   duty_d;
    logic              valid_q,  valid_d;

    // Divider interface
    logic              div_done;
    logic [CNT_W-1:0]  div_per;
    logic [CNT_W-1:0]  div_hi;
    logic [DUTY_W-1:0] div_duty;

    // Both edges come out of the same sync+delay chain, so the falling
    // edge needs no separate detector: hi_cnt just follows the synced level.
    assign rise = sync2_q & ~dly_q;

    always_comb begin
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        armed_d   = armed_q;
        stuck_d   = stuck_q;
        period_d  = period_q;
        high_d    = high_q;
        duty_d    = duty_q;
        valid_d   = 1'b0;
        capture   = 1'b0;

        stuck_fire = (per_cnt_q == CNT_MAX) && !stuck_q && !rise;

        if (rise) begin
            // The rise cycle itself is the first cycle of the new period
            // and is high, hence restart at 1 rather than 0.
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
            if (armed_q) begin
                capture = 1'b1;
            end else begin
                armed_d = 1'b1;
                stuck_d = 1'b0;
            end
        end else begin
            if (per_cnt_q != CNT_MAX) begin
                per_cnt_d = per_cnt_q + CNT_ONE;
            end
            if (sync2_q && (hi_cnt_q != CNT_MAX)) begin
                hi_cnt_d = hi_cnt_q + CNT_ONE;
            end
        end

        // Stuck forcing takes priority over a coincident divider result,
        // so only one valid is issued in that cycle.
        if (stuck_fire) begin
            stuck_d  = 1'b1;
            armed_d  = 1'b0;
            period_d = '0;
            high_d   = '0;
            duty_d   = sync2_q ? DUTY_MAX_V : '0;
            valid_d  = 1'b1;
        end else if (div_done && !stuck_q) begin
            period_d = div_per;
            high_d   = div_hi;
            duty_d   = div_duty;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            dly_q     <= 1'b0;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            armed_q   <= 1'b0;
            stuck_q   <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            sync1_q   <= pwm_in;
            sync2_q   <= sync1_q;
            dly_q     <= sync2_q;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            armed_q   <= armed_d;
            stuck_q   <= stuck_d;
            period_q  <= period_d;
            high_q    <= high_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
        end
    end

    // Captures arriving while the divider is busy are ignored by it;
    // the counters above have already restarted regardless.
    pwm_duty_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start_i (capture),
        .per_i   (per_cnt_q),
        .hi_i    (hi_cnt_q),
        .done_o  (div_done),
        .per_o   (div_per),
        .hi_o    (div_hi),
        .duty_o  (div_duty)
    );

    assign period_out = period_q;
    assign high_out   = high_q;
    assign duty_out   = duty_q;
    assign valid      = valid_q;
    assign stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
module tb_pwm_duty_decoder;

    localparam int unsigned CNT_W = 8;
    localparam int MAXC = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             pwm_in;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic [3:0]       duty_out;
    logic             valid;
    logic             stuck;

    always #5 clk = ~clk;

    pwm_duty_decoder #(
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .period_out (period_out),
        .high_out   (high_out),
        .duty_out   (duty_out),
        .valid      (valid),
        .stuck      (stuck)
    );

    typedef struct {
        int per;
        int hi;
        int duty;
        int stk;
        int cyc;
    } exp_t;

    typedef struct {
        int val;
        int cyc;
    } lvl_t;

    exp_t sbq[$];
    lvl_t stq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    // Reference model state (input-side view, cycle indices of drive)
    bit m_prev, m_armed, m_stuck, m_has_rise;
    int m_last_rise, m_hi_acc, m_next_ok;
    int m_rst_at = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic model_reset(input int k);
        exp_t keep[$];
        lvl_t keep_s[$];
        m_prev = 0; m_armed = 0; m_stuck = 0; m_has_rise = 0;
        m_last_rise = 0; m_hi_acc = 0; m_next_ok = 0;
        m_rst_at = k + 1;
        foreach (sbq[i]) if (sbq[i].cyc <= k) keep.push_back(sbq[i]);
        sbq = keep;
        foreach (stq[i]) if (stq[i].cyc <= k) keep_s.push_back(stq[i]);
        stq = keep_s;
        stq.push_back('{val: 0, cyc: k + 1});
    endtask

    // Plain arithmetic on input edge times: period = distance between rises,
    // high = count of high cycles since last rise, duty = round(10*hi/per).
    task automatic model_step(input bit lvl, input int k);
        int per, hi, q;
        if (lvl && !m_prev) begin
            if (m_stuck) begin
                m_stuck = 0;
                m_armed = 1;
            end else if (!m_armed) begin
                m_armed = 1;
            end else begin
                per = k - m_last_rise;
                hi  = m_hi_acc;
                if (k >= m_next_ok) begin
                    q = (hi * 10 + per / 2) / per;
                    sbq.push_back('{per: per, hi: hi, duty: (q > 10) ? 10 : q,
                                    stk: 0, cyc: k + q + 5});
                    m_next_ok = k + q + 3;
                end
            end
            m_last_rise = k;
            m_hi_acc    = 1;
            m_has_rise  = 1;
        end else begin
            if (lvl) m_hi_acc++;
            if (m_has_rise && !m_stuck && (k - m_last_rise == MAXC)) begin
                m_stuck = 1;
                m_armed = 0;
                sbq.push_back('{per: 0, hi: 0, duty: lvl ? 10 : 0, stk: 1, cyc: k + 3});
            end
        end
        m_prev = lvl;
        stq.push_back('{val: int'(m_stuck), cyc: k + 3});
    endtask

    task automatic drive(input bit lvl, input bit r);
        int k;
        @(posedge clk);
        #1;
        rst    = r;
        pwm_in = lvl;
        k      = cyc;
        if (r) model_reset(k);
        else   model_step(lvl, k);
    endtask

    task automatic wave(input int per, input int hi, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++)       drive(1'b1, 1'b0);
            for (int i = 0; i < per - hi; i++) drive(1'b0, 1'b0);
        end
    endtask

    // Monitor / scoreboard
    int last_per = 0, last_hi = 0, last_duty = 0, cur_stuck = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            if (cyc == m_rst_at) begin
                last_per = 0; last_hi = 0; last_duty = 0;
            end
            while (stq.size() > 0 && stq[0].cyc <= cyc) begin
                lvl_t s;
                s = stq.pop_front();
                cur_stuck = s.val;
            end
            check("stuck_level", int'(stuck), cur_stuck);
            if (valid) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid @cyc %0d: got valid=1, expected none (period=%0d high=%0d duty=%0d)",
                             cyc, period_out, high_out, duty_out);
                end else begin
                    e = sbq.pop_front();
                    check("valid_cycle", cyc, e.cyc);
                    check("period_out", int'(period_out), e.per);
                    check("high_out", int'(high_out), e.hi);
                    check("duty_out", int'(duty_out), e.duty);
                    check("stuck_at_valid", int'(stuck), e.stk);
                    last_per = e.per; last_hi = e.hi; last_duty = e.duty;
                end
            end else begin
                check("hold_outputs",
                      (int'(period_out) << (CNT_W + 4)) | (int'(high_out) << 4) | int'(duty_out),
                      (last_per << (CNT_W + 4)) | (last_hi << 4) | last_duty);
                if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                    e = sbq.pop_front();
                    check("missing_valid_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int per, hi, reps;
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (3) drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_period", int'(period_out), 0);
        check("reset_high", int'(high_out), 0);
        check("reset_duty", int'(duty_out), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_stuck", int'(stuck), 0);

        wave(10, 5, 4);
        wave(10, 9, 3);
        wave(7, 3, 4);
        wave(4, 3, 5);
        wave(20, 1, 3);
        wave(2, 1, 12);

        // Line stuck low, then stuck high, then recovery
        repeat (MAXC + 10) drive(1'b0, 1'b0);
        repeat (MAXC + 10) drive(1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b0);
        wave(10, 5, 3);

        // Reset pulse while the divider is working on a capture
        repeat (4) drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        repeat (3) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        wave(10, 5, 3);

        for (int s = 0; s < 25; s++) begin
            per  = $urandom_range(40, 2);
            hi   = $urandom_range(per - 1, 1);
            reps = $urandom_range(3, 1);
            wave(per, hi, reps);
        end

        repeat (40) drive(1'b0, 1'b0);
        @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_duty_decoder.md
# pwm_duty_decoder

Receive-side counterpart to the team's PWM generator. Measures the period and high time of an incoming PWM waveform in `clk` cycles, converts them to a duty cycle in tenths (0–10, the same scale the generator uses), and reports each result with a one-cycle valid pulse. It sits on a loop-back or external pin to check or track a PWM source. It also flags a stuck line (no rising edge) as 0 % or 100 %.

## Interface
Parameters:
- `CNT_W`, 16: width of the period and high-time counters and outputs.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous reset, active-high.
- `pwm_in`  in  1  asynchronous PWM input.
- `period_out`  out  CNT_W  cycles between the last two rising edges. Reset 0.
- `high_out`  out  CNT_W  high cycles in that period. Reset 0.
- `duty_out`  out  4  duty in tenths, 0..10, rounded to nearest. Reset 0.
- `valid`  out  1  one-cycle pulse when the three outputs above update. Reset 0.
- `stuck`  out  1  level: no rising edge seen for 2^CNT_W−1 cycles. Reset 0.

## Operation
- **Input conditioning:** `pwm_in` passes through a 2-FF synchronizer, then one delay register. `rise` = sync & ~dly; `fall` = ~sync & dly. Both edges have equal delay, so measured counts are exact.
- **Counters:**
  - `per_cnt` increments every cycle and saturates at 2^CNT_W−1.
  - `hi_cnt` increments while sync is high and saturates the same way.
  - On `rise`, both counters restart (per_cnt=1, hi_cnt=1 counting the rise cycle).
- **Arming:** after reset or after `stuck`, the first `rise` only arms the block; nothing is captured. Each later `rise` is a capture event: period = per_cnt, high = hi_cnt, both taken before the restart.
- **Divider FSM** (states IDLE, DIV, DONE):
  - IDLE: on a capture event, load cap_per and cap_hi, set rem = cap_hi*10 + (cap_per>>1) (width CNT_W+4), q = 0, and go to DIV.
  - If a capture event arrives while in DIV or DONE, it is dropped. The counters still restart.
  - DIV: if rem ≥ cap_per, then rem −= cap_per and q++. Otherwise go to DONE.
  - DONE: drive period_out=cap_per, high_out=cap_hi, duty_out=min(q,10), valid=1, then return to IDLE.
  - q never exceeds 10 because high ≤ period. The clamp is a guard only.
- **Stuck handling:**
  - When per_cnt reaches saturation, `stuck` asserts and the block disarms.
  - duty_out is forced to 10 if sync is high, else 0. period_out and high_out are forced to 0. valid pulses once.
  - While stuck, a level change on the input causes no new valid.
  - The next `rise` clears `stuck` and re-arms the block; it does not capture.
- **Reset mid-operation:** returns the FSM to IDLE and the block to disarmed, zeroes all outputs and counters, and discards any pending capture. No valid is produced.

## Timing
- Input to edge detect: an edge on `pwm_in` is seen as `rise`/`fall` 2–3 `clk` edges later.
- Capture cycle C is the cycle the FSM enters DIV. valid is registered and high in cycle C+Q+2, where Q is the final quotient. Worst case is C+12.
- Outputs hold their values between valid pulses.
- If stuck assertion and a DONE cycle coincide, the stuck forcing wins and only one valid is issued.
- Minimum input period is 2 cycles. Results update at most once every Q+3 cycles.

## Structure
- Shared package `pwm_pkg`:
  - `DUTY_MAX` = 10.
  - `DUTY_W` = 4.
  - FSM state enum `dec_state_t` {IDLE, DIV, DONE}.
  - The generator reuses `DUTY_MAX`.
- One sub-module, `pwm_duty_div`: repeated-subtraction divider with start/done handshake, holding rem, q and the clamp.
- Synchronizer, edge detect, counters and the stuck logic stay in the top module.

## Test plan
- 10-cycle period, 5 high, repeated → first valid after the second rise; period_out=10, high_out=5, duty_out=5; values stable on later pulses.
- Period 7, high 3 → duty_out=4 (33/7). Period 4, high 3 → duty_out=8 (32/4). Period 20, high 1 → duty_out=1 (20/20).
- Constant low after lock → stuck=1 after 2^CNT_W−1 cycles, one valid, duty_out=0. Repeat with constant high → duty_out=10. Then the next rise clears stuck, the following rise produces a normal valid.
- Period 2, high 1, continuous → duty_out=5; every valid spaced ≥8 cycles apart; captures during DIV dropped without corrupting outputs.
- Assert `rst` for one cycle during DIV → no valid; all outputs 0 the following cycle; re-arm needs two rises.
- Change duty 5→9 at the input → next valid shows duty_out=9, high_out=9, period_out=10.
